parity_frame_gen: RTL
=====================

// Module: parity_frame_gen
// PURPOSE
//   AXI-Stream byte-frame generator that sits directly upstream of parity_tester.
//   Takes raw payload frames, forwards each byte through a 1-deep output register,
//   then appends one even-parity byte (XOR of all payload bytes) carrying tlast.
//   Optional single-shot error injection corrupts the parity byte to exercise
//   the downstream checker. Counts completed frames.
// PARAMETERS
//   MAX_LEN   64   max payload bytes per frame; longer frames are cut (range 1..65535)
//   CNT_W     16   width of frame_cnt
// PORTS
//   a_clk          in   1      single clock, all logic rising-edge
//   axis_areset    in   1      synchronous, active-high reset
//   axis_s_tvalid  in   1      payload beat valid
//   axis_s_tdata   in   8      payload byte
//   axis_s_tready  out  1      payload beat accepted when tvalid&tready
//   axis_s_tlast   in   1      last payload byte of frame
//   axis_m_tvalid  out  1      output beat valid (to parity_tester slave)
//   axis_m_tdata   out  8      payload byte, or parity byte on tlast beat
//   axis_m_tready  in   1      downstream ready
//   axis_m_tlast   out  1      high only on the appended parity byte
//   inject_err     in   1      1-cycle pulse: corrupt next emitted parity byte
//   trunc_err      out  1      1-cycle pulse: frame cut at MAX_LEN
//   frame_cnt      out  CNT_W  parity bytes emitted since reset (wraps)
//   busy           out  1      frame in progress or output register occupied
// BEHAVIOUR
//   Reset (sync, axis_areset=1 at edge): state=PAYLOAD, byte_cnt=0, parity=0,
//     inj_pend=0, axis_m_tvalid=0, axis_m_tdata=0, axis_m_tlast=0, trunc_err=0,
//     frame_cnt=0. Reset mid-frame drops the partial frame; no parity byte emitted.
//   slot_free = !axis_m_tvalid | axis_m_tready (output register empty or draining).
//   States:
//     PAYLOAD: axis_s_tready = slot_free. On s-handshake: m_tdata<=s_tdata,
//       m_tlast<=0, m_tvalid<=1, parity<=parity^s_tdata, byte_cnt++.
//       If s_tlast or byte_cnt==MAX_LEN-1 -> PARITY; byte_cnt<=0.
//       If byte_cnt==MAX_LEN-1 and !s_tlast: trunc_err pulses 1 cycle; next byte
//       starts a new frame.
//       If no s-handshake and axis_m_tready: m_tvalid<=0.
//     PARITY: axis_s_tready=0. When slot_free: m_tdata<=parity^{7'b0,inj_pend},
//       m_tlast<=1, m_tvalid<=1, parity<=0, inj_pend<=0, frame_cnt++ -> PAYLOAD.
//   Latency: s-handshake to m_tvalid = 1 cycle; parity byte follows last payload
//     byte on the next free slot (back-to-back at full rate: 1 bubble on input
//     per frame, none on output).
//   Throughput: 1 beat/cycle when axis_m_tready held high.
//   AXIS rules: m_tvalid/tdata/tlast stable while m_tvalid & !m_tready; tvalid
//     never deasserted without handshake. s_tready may depend combinationally on
//     axis_m_tready (no comb path s_tvalid -> m_*).
//   inject_err: sets inj_pend (sticky); cleared only when a parity byte loads.
//     inject_err coincident with parity load: current byte uses old inj_pend,
//     new pulse stays pending for next frame.
//   frame_cnt wraps 2^CNT_W-1 -> 0. busy = (byte_cnt!=0)|(state==PARITY)|m_tvalid.
// TESTING
//   1) Frame 01,02,04 (tlast on 04), m_tready=1 -> out 01,02,04,07(tlast); frame_cnt=1.
//   2) 1-byte frame A5 w/ tlast -> out A5, A5(tlast); s_tready low exactly 1 cycle.
//   3) inject_err pulse then frame 0F,F0 -> parity byte FE (FF^01); next frame clean.
//   4) MAX_LEN=4, 6-byte frame 11..16 no early tlast -> 11,12,13,14,04(tlast), trunc_err
//      pulse; then 15,16,03(tlast); frame_cnt=2.
//   5) Random m_tready backpressure over 100 random frames -> scoreboard exact bytes,
//      tdata/tlast stable under stall, every frame XOR incl parity == 00.
//   6) axis_areset asserted mid-frame after 2 bytes -> m_tvalid=0 next cycle,
//      no parity emitted, frame_cnt=0, next frame parity computed from fresh 00.

Source files
------------

// File: rtl/parity_frame_gen.sv
// parity_frame_gen: AXI-Stream byte framer that forwards payload bytes and appends an even-parity byte with tlast
//   a_clk, axis_areset        : clock, synchronous active-high reset
//   axis_s_tvalid/tdata/tlast : payload input beat; axis_s_tready accepts it
//   axis_m_tvalid/tdata/tlast : output beat (payload bytes, then parity byte with tlast); axis_m_tready from downstream
//   inject_err                : pulse that flips bit 0 of the next emitted parity byte
//   trunc_err                 : pulse when a frame is cut at MAX_LEN bytes
//   frame_cnt                 : parity bytes emitted since reset, wrapping
//   busy                      : frame in progress or output register occupied
module parity_frame_gen #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             a_clk,
  input  logic             axis_areset,
  input  logic             axis_s_tvalid,
  input  logic [7:0]       axis_s_tdata,
  output logic             axis_s_tready,
  input  logic             axis_s_tlast,
  output logic             axis_m_tvalid,
  output logic [7:0]       axis_m_tdata,
  input  logic             axis_m_tready,
  output logic             axis_m_tlast,
  input  logic             inject_err,
  output logic             trunc_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);
  typedef enum logic {PAYLOAD, PARITY} state_t;
  localparam logic [15:0] LAST_IDX = 16'(MAX_LEN - 1);
  state_t      state, state_nxt;
  logic [15:0] byte_cnt;
  logic [7:0]  parity;
  logic        inj_pend, slot_free, s_hs, p_load, at_max;
  always_comb begin
    slot_free     = !axis_m_tvalid | axis_m_tready;
    axis_s_tready = (state == PAYLOAD) & slot_free;
    s_hs          = axis_s_tvalid & axis_s_tready;
    p_load        = (state == PARITY) & slot_free;
    at_max        = byte_cnt == LAST_IDX;
    state_nxt     = (s_hs & (axis_s_tlast | at_max)) ? PARITY : p_load ? PAYLOAD : state;
  end
  always_ff @(posedge a_clk) begin
    if (axis_areset) begin
      state         <= PAYLOAD;
      byte_cnt      <= '0;
      parity        <= '0;
      inj_pend      <= 1'b0;
      axis_m_tvalid <= 1'b0;
      axis_m_tdata  <= '0;
      axis_m_tlast  <= 1'b0;
      trunc_err     <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      trunc_err <= s_hs & at_max & !axis_s_tlast;
      // a pulse landing on the parity load belongs to the following frame
      inj_pend  <= p_load ? inject_err : inj_pend | inject_err;
      if (s_hs) begin
        axis_m_tdata  <= axis_s_tdata;
        axis_m_tlast  <= 1'b0;
        axis_m_tvalid <= 1'b1;
        parity        <= parity ^ axis_s_tdata;
        byte_cnt      <= (axis_s_tlast | at_max) ? 16'd0 : byte_cnt + 16'd1;
      end else if (p_load) begin
        axis_m_tdata  <= parity ^ {7'b0, inj_pend};
        axis_m_tlast  <= 1'b1;
        axis_m_tvalid <= 1'b1;
        parity        <= '0;
        frame_cnt     <= frame_cnt + CNT_W'(1);
      end else if (axis_m_tready) begin
        axis_m_tvalid <= 1'b0;
      end
    end
  end
  assign busy = (byte_cnt != 16'd0) | (state == PARITY) | axis_m_tvalid;
endmodule
